// File: rtl/syn_ram_pkg.sv
// rtl/syn_ram_pkg.sv - shared FSM encoding and read-during-write policy constants
package syn_ram_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } ram_state_t;

   localparam int RDW_READ_OLD      = 0;
   localparam int RDW_WRITE_THROUGH = 1;

endpackage

// File: rtl/syn_dual_port_ram_if.sv
// rtl/syn_dual_port_ram_if.sv - write port, read port and status bundle of the dual-port RAM
interface syn_dual_port_ram_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   logic [ADDR_WIDTH-1:0] addr_0;
   logic                  we_0;
   logic [DATA_WIDTH-1:0] data_0;
   logic [ADDR_WIDTH-1:0] addr_1;
   logic                  re_1;
   logic [DATA_WIDTH-1:0] data_1;
   logic                  valid_1;
   logic                  collision_1;
   logic                  addr_err;
   logic                  ready;

   modport master (
      output addr_0, we_0, data_0, addr_1, re_1,
      input  data_1, valid_1, collision_1, addr_err, ready
   );

   modport slave (
      input  addr_0, we_0, data_0, addr_1, re_1,
      output data_1, valid_1, collision_1, addr_err, ready
   );
endinterface

// File: rtl/syn_ram_rd_pipe.sv
// rtl/syn_ram_rd_pipe.sv - one- or two-stage read result pipeline, flushed by rst
module syn_ram_rd_pipe #(
   parameter int DATA_WIDTH = 8,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_collision,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_collision
);
   logic                  s1_valid;
   logic                  s1_collision;
   logic [DATA_WIDTH-1:0] s1_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid     <= 1'b0;
         s1_collision <= 1'b0;
         s1_data      <= '0;
      end else begin
         s1_valid     <= in_valid;
         s1_collision <= in_valid & in_collision;
         if (in_valid) s1_data <= in_data;
      end
   end

   generate
      if (RD_LATENCY == 2) begin : g_lat2
         logic                  s2_valid;
         logic                  s2_collision;
         logic [DATA_WIDTH-1:0] s2_data;

         // data only advances with a valid so the output holds between pulses
         always_ff @(posedge clk) begin
            if (rst) begin
               s2_valid     <= 1'b0;
               s2_collision <= 1'b0;
               s2_data      <= '0;
            end else begin
               s2_valid     <= s1_valid;
               s2_collision <= s1_collision;
               if (s1_valid) s2_data <= s1_data;
            end
         end

         assign out_valid     = s2_valid;
         assign out_collision = s2_collision;
         assign out_data      = s2_data;
      end else begin : g_lat1
         assign out_valid     = s1_valid;
         assign out_collision = s1_collision;
         assign out_data      = s1_data;
      end
   endgenerate
endmodule

// File: rtl/syn_dual_port_ram.sv
// rtl/syn_dual_port_ram.sv - simple dual-port RAM with init sweep, RDW policy and address checking
module syn_dual_port_ram #(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    ADDR_WIDTH = 4,
   parameter int                    DATA_DEPTH = (1 << ADDR_WIDTH),
   parameter int                    RD_LATENCY = 1,
   parameter int                    RDW_MODE   = 0,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input logic               clk,
   input logic               rst,
   syn_dual_port_ram_if.slave ram_bus
);
   import syn_ram_pkg::*;

   localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DATA_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(DATA_DEPTH - 1);
   localparam bit                    FWD_WRITE = (RDW_MODE == RDW_WRITE_THROUGH);

   ram_state_t            state;
   logic [ADDR_WIDTH-1:0] cnt;
   logic                  ready_q;
   logic                  addr_err_q;
   logic [DATA_WIDTH-1:0] ram [DATA_DEPTH];

   logic [ADDR_WIDTH-1:0] addr_0;
   logic [ADDR_WIDTH-1:0] addr_1;
   logic [DATA_WIDTH-1:0] data_0;
   logic                  run, wr_ok, rd_ok, wr_hit, rd_hit, collide;
   logic [ADDR_WIDTH-1:0] rd_idx;
   logic [DATA_WIDTH-1:0] rd_word;

   assign addr_0  = ram_bus.addr_0;
   assign addr_1  = ram_bus.addr_1;
   assign data_0  = ram_bus.data_0;
   assign run     = (state == RUN);
   assign wr_ok   = {1'b0, addr_0} < DEPTH_W;
   assign rd_ok   = {1'b0, addr_1} < DEPTH_W;
   assign wr_hit  = run & ram_bus.we_0 & wr_ok;
   assign rd_hit  = run & ram_bus.re_1;
   assign collide = wr_hit & rd_hit & rd_ok & (addr_0 == addr_1);
   assign rd_idx  = rd_ok ? addr_1 : '0;

   // out-of-range reads still complete, returning the init pattern
   always_comb begin
      rd_word = INIT_VALUE;
      if (rd_ok) rd_word = (collide && FWD_WRITE) ? data_0 : ram[rd_idx];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= INIT;
         cnt        <= '0;
         ready_q    <= 1'b0;
         addr_err_q <= 1'b0;
      end else begin
         addr_err_q <= run & ((ram_bus.we_0 & ~wr_ok) | (ram_bus.re_1 & ~rd_ok));
         case (state)
            INIT: begin
               cnt <= cnt + 1'b1;
               if (cnt == LAST_IDX) begin
                  state   <= RUN;
                  ready_q <= 1'b1;
                  cnt     <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!run) ram[cnt] <= INIT_VALUE;
      else if (wr_hit && !rst) ram[addr_0] <= data_0;
   end

   syn_ram_rd_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .RD_LATENCY (RD_LATENCY)
   ) u_rd_pipe (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (rd_hit),
      .in_data       (rd_word),
      .in_collision  (collide),
      .out_valid     (ram_bus.valid_1),
      .out_data      (ram_bus.data_1),
      .out_collision (ram_bus.collision_1)
   );

   assign ram_bus.ready    = ready_q;
   assign ram_bus.addr_err = addr_err_q;
endmodule

// File: tb/tb_syn_dual_port_ram.sv
// tb/tb_syn_dual_port_ram.sv - bench for two RAM configurations driven in lockstep
module tb_syn_dual_port_ram;
   import syn_ram_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   syn_dual_port_ram_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if_a ();
   syn_dual_port_ram_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if_b ();

   syn_dual_port_ram #(
      .DATA_WIDTH(8), .ADDR_WIDTH(4), .DATA_DEPTH(16), .RD_LATENCY(2),
      .RDW_MODE(RDW_READ_OLD), .INIT_VALUE(8'h00)
   ) u_a (.clk(clk), .rst(rst), .ram_bus(if_a));

   syn_dual_port_ram #(
      .DATA_WIDTH(8), .ADDR_WIDTH(4), .DATA_DEPTH(12), .RD_LATENCY(1),
      .RDW_MODE(RDW_WRITE_THROUGH), .INIT_VALUE(8'h3C)
   ) u_b (.clk(clk), .rst(rst), .ram_bus(if_b));

   typedef struct {int e; logic [7:0] d; logic c;} obs_t;

   int total = 0;
   int bad   = 0;
   int edge_n = 0;

   // reference model: instance 0 = u_a, instance 1 = u_b
   int         depth_m [2] = '{16, 12};
   int         lat_m   [2] = '{2, 1};
   bit         wt_m    [2] = '{1'b0, 1'b1};
   logic [7:0] initv_m [2] = '{8'h00, 8'h3C};
   logic [7:0] mem_m [2][16];
   int         ev_m [2];
   logic       sv [2][4];
   logic [7:0] sd [2][4];
   logic       sc [2][4];
   logic       exp_v [2], exp_c [2], exp_e [2], exp_r [2];
   logic [7:0] exp_d [2];

   logic       cur_we, cur_re;
   logic [3:0] cur_wa, cur_ra;
   logic [7:0] cur_wd;

   obs_t obs_a[$], obs_b[$];
   int   erra[$], errb[$];

   task automatic model_edge(input int en);
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            ev_m[k] = 0;
            exp_v[k] = 0; exp_c[k] = 0; exp_e[k] = 0; exp_r[k] = 0; exp_d[k] = 8'h00;
            for (int j = 0; j < 4; j++) sv[k][j] = 0;
            for (int j = 0; j < 16; j++) mem_m[k][j] = initv_m[k];
         end else begin
            bit err;
            int due;
            err = 0;
            due = en + lat_m[k] - 1;
            if (ev_m[k] >= depth_m[k]) begin
               if (cur_re) begin
                  if (int'(cur_ra) < depth_m[k]) begin
                     sd[k][due % 4] = (cur_we && cur_wa == cur_ra && wt_m[k]) ? cur_wd : mem_m[k][cur_ra];
                     sc[k][due % 4] = cur_we && (cur_wa == cur_ra);
                  end else begin
                     sd[k][due % 4] = initv_m[k];
                     sc[k][due % 4] = 0;
                     err = 1;
                  end
                  sv[k][due % 4] = 1;
               end
               if (cur_we) begin
                  if (int'(cur_wa) < depth_m[k]) mem_m[k][cur_wa] = cur_wd;
                  else err = 1;
               end
            end
            ev_m[k]++;
            exp_r[k] = (ev_m[k] >= depth_m[k]);
            exp_e[k] = err;
            exp_v[k] = sv[k][en % 4];
            exp_c[k] = sv[k][en % 4] ? sc[k][en % 4] : 1'b0;
            if (sv[k][en % 4]) exp_d[k] = sd[k][en % 4];
            sv[k][en % 4] = 0;
         end
      end
   endtask

   task automatic step(input logic w, input logic [3:0] wa, input logic [7:0] wd,
                       input logic r, input logic [3:0] ra);
      cur_we = w; cur_wa = wa; cur_wd = wd; cur_re = r; cur_ra = ra;
      if_a.we_0 = w; if_a.addr_0 = wa; if_a.data_0 = wd; if_a.re_1 = r; if_a.addr_1 = ra;
      if_b.we_0 = w; if_b.addr_0 = wa; if_b.data_0 = wd; if_b.re_1 = r; if_b.addr_1 = ra;
      model_edge(edge_n + 1);
      @(posedge clk);
      #1;
      edge_n++;
      if (if_a.valid_1) obs_a.push_back('{edge_n, if_a.data_1, if_a.collision_1});
      if (if_b.valid_1) obs_b.push_back('{edge_n, if_b.data_1, if_b.collision_1});
      if (if_a.addr_err) erra.push_back(edge_n);
      if (if_b.addr_err) errb.push_back(edge_n);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 4'h0, 8'h00, 1'b0, 4'h0);
   endtask

   task automatic clear_obs();
      obs_a.delete(); obs_b.delete(); erra.delete(); errb.delete();
   endtask

   task automatic read_all();
      clear_obs();
      for (int i = 0; i < 16; i++) step(1'b0, 4'h0, 8'h00, 1'b1, 4'(i));
      idle(3);
   endtask

   task automatic test_reset();
      int ra, rb;
      rst = 1'b1;
      idle(3);
      total++;
      if ({if_a.ready, if_a.valid_1, if_a.collision_1, if_a.addr_err, if_a.data_1} !== 12'h0) begin
         bad++; $display("FAIL reset_state_a: got %0h want 0",
                         {if_a.ready, if_a.valid_1, if_a.collision_1, if_a.addr_err, if_a.data_1});
      end
      total++;
      if ({if_b.ready, if_b.valid_1, if_b.collision_1, if_b.addr_err, if_b.data_1} !== 12'h0) begin
         bad++; $display("FAIL reset_state_b: got %0h want 0",
                         {if_b.ready, if_b.valid_1, if_b.collision_1, if_b.addr_err, if_b.data_1});
      end
      clear_obs();
      rst = 1'b0;
      ra = -1; rb = -1;
      for (int i = 1; i <= 40; i++) begin
         if (i <= 10) step(1'b1, 4'($urandom_range(0, 15)), 8'($urandom), 1'b1, 4'($urandom_range(0, 15)));
         else idle(1);
         if (ra < 0 && if_a.ready === 1'b1) ra = i;
         if (rb < 0 && if_b.ready === 1'b1) rb = i;
      end
      total++;
      if (ra !== 16) begin bad++; $display("FAIL ready_rise_a: got %0d want 16", ra); end
      total++;
      if (rb !== 12) begin bad++; $display("FAIL ready_rise_b: got %0d want 12", rb); end
      total++;
      if (obs_a.size() + obs_b.size() + erra.size() + errb.size() !== 0) begin
         bad++; $display("FAIL init_ignores_requests: got %0d events want 0",
                         obs_a.size() + obs_b.size() + erra.size() + errb.size());
      end
   endtask

   task automatic test_init_contents();
      read_all();
      total++;
      if (obs_a.size() !== 16) begin bad++; $display("FAIL init_count_a: got %0d want 16", obs_a.size()); end
      total++;
      if (obs_b.size() !== 16) begin bad++; $display("FAIL init_count_b: got %0d want 16", obs_b.size()); end
      for (int i = 0; i < obs_a.size(); i++) begin
         total++;
         if (obs_a[i].d !== 8'h00) begin bad++; $display("FAIL init_word_a[%0d]: got %0h want 0", i, obs_a[i].d); end
      end
      for (int i = 0; i < obs_b.size(); i++) begin
         total++;
         if (obs_b[i].d !== 8'h3C) begin bad++; $display("FAIL init_word_b[%0d]: got %0h want 3c", i, obs_b[i].d); end
      end
      total++;
      if (erra.size() !== 0 || errb.size() !== 4) begin
         bad++; $display("FAIL init_addr_err: got a=%0d b=%0d want a=0 b=4", erra.size(), errb.size());
      end
   endtask

   task automatic test_latency();
      int er;
      step(1'b1, 4'd3, 8'hA5, 1'b0, 4'h0);
      clear_obs();
      step(1'b0, 4'h0, 8'h00, 1'b1, 4'd3);
      er = edge_n;
      idle(3);
      total++;
      if (obs_a.size() !== 1 || obs_b.size() !== 1) begin
         bad++; $display("FAIL latency_count: got a=%0d b=%0d want 1 1", obs_a.size(), obs_b.size());
      end
      if (obs_a.size() > 0) begin
         total++;
         if (obs_a[0].d !== 8'hA5 || obs_a[0].e !== er + 1) begin
            bad++; $display("FAIL latency_a: got d=%0h cyc=%0d want d=a5 cyc=%0d", obs_a[0].d, obs_a[0].e, er + 1);
         end
      end
      if (obs_b.size() > 0) begin
         total++;
         if (obs_b[0].d !== 8'hA5 || obs_b[0].e !== er) begin
            bad++; $display("FAIL latency_b: got d=%0h cyc=%0d want d=a5 cyc=%0d", obs_b[0].d, obs_b[0].e, er);
         end
      end
   endtask

   task automatic test_collision();
      step(1'b1, 4'd5, 8'h11, 1'b0, 4'h0);
      clear_obs();
      step(1'b1, 4'd5, 8'h22, 1'b1, 4'd5);
      idle(2);
      step(1'b0, 4'h0, 8'h00, 1'b1, 4'd5);
      idle(3);
      total++;
      if (obs_a.size() !== 2 || obs_b.size() !== 2) begin
         bad++; $display("FAIL collision_count: got a=%0d b=%0d want 2 2", obs_a.size(), obs_b.size());
      end else begin
         total++;
         if ({obs_a[0].d, obs_a[0].c} !== {8'h11, 1'b1}) begin
            bad++; $display("FAIL rdw_old_a: got d=%0h c=%0b want d=11 c=1", obs_a[0].d, obs_a[0].c);
         end
         total++;
         if ({obs_b[0].d, obs_b[0].c} !== {8'h22, 1'b1}) begin
            bad++; $display("FAIL rdw_through_b: got d=%0h c=%0b want d=22 c=1", obs_b[0].d, obs_b[0].c);
         end
         total++;
         if ({obs_a[1].d, obs_a[1].c, obs_b[1].d, obs_b[1].c} !== {8'h22, 1'b0, 8'h22, 1'b0}) begin
            bad++; $display("FAIL after_collision: got a=%0h/%0b b=%0h/%0b want 22/0 22/0",
                            obs_a[1].d, obs_a[1].c, obs_b[1].d, obs_b[1].c);
         end
      end
   endtask

   task automatic test_addr_err();
      int ew;
      logic [7:0] want;
      clear_obs();
      step(1'b1, 4'd13, 8'h7E, 1'b0, 4'h0);
      ew = edge_n;
      idle(2);
      total++;
      if (errb.size() !== 1 || erra.size() !== 0) begin
         bad++; $display("FAIL wr_addr_err_count: got a=%0d b=%0d want 0 1", erra.size(), errb.size());
      end else begin
         total++;
         if (errb[0] !== ew) begin bad++; $display("FAIL wr_addr_err_cycle: got %0d want %0d", errb[0], ew); end
      end
      clear_obs();
      step(1'b0, 4'h0, 8'h00, 1'b1, 4'd13);
      idle(3);
      total++;
      if (obs_a.size() !== 1 || obs_b.size() !== 1 || errb.size() !== 1 || erra.size() !== 0) begin
         bad++; $display("FAIL rd_oob_events: got va=%0d vb=%0d ea=%0d eb=%0d want 1 1 0 1",
                         obs_a.size(), obs_b.size(), erra.size(), errb.size());
      end else begin
         total++;
         if ({obs_a[0].d, obs_b[0].d} !== {8'h7E, 8'h3C}) begin
            bad++; $display("FAIL rd_oob_data: got a=%0h b=%0h want a=7e b=3c", obs_a[0].d, obs_b[0].d);
         end
      end
      read_all();
      for (int i = 0; i < obs_b.size() && i < 12; i++) begin
         want = (i == 3) ? 8'hA5 : (i == 5) ? 8'h22 : 8'h3C;
         total++;
         if (obs_b[i].d !== want) begin bad++; $display("FAIL inrange_word_b[%0d]: got %0h want %0h", i, obs_b[i].d, want); end
      end
   endtask

   task automatic test_reset_flush();
      int er, ra, rb, late;
      clear_obs();
      step(1'b0, 4'h0, 8'h00, 1'b1, 4'd1);
      step(1'b0, 4'h0, 8'h00, 1'b1, 4'd2);
      rst = 1'b1;
      er = edge_n + 1;
      step(1'b0, 4'h0, 8'h00, 1'b1, 4'd3);
      step(1'b0, 4'h0, 8'h00, 1'b1, 4'd4);
      rst = 1'b0;
      ra = -1; rb = -1;
      for (int i = 1; i <= 40; i++) begin
         idle(1);
         if (ra < 0 && if_a.ready === 1'b1) ra = i;
         if (rb < 0 && if_b.ready === 1'b1) rb = i;
      end
      late = 0;
      foreach (obs_a[i]) if (obs_a[i].e >= er) late++;
      foreach (obs_b[i]) if (obs_b[i].e >= er) late++;
      total++;
      if (late !== 0) begin bad++; $display("FAIL flush_valid: got %0d late valids want 0", late); end
      total++;
      if (ra !== 16 || rb !== 12) begin bad++; $display("FAIL rerun_ready: got a=%0d b=%0d want 16 12", ra, rb); end
      read_all();
      total++;
      if (obs_a.size() !== 16 || obs_b.size() !== 16) begin
         bad++; $display("FAIL reinit_count: got a=%0d b=%0d want 16 16", obs_a.size(), obs_b.size());
      end
      for (int i = 0; i < obs_a.size() && i < obs_b.size(); i++) begin
         total++;
         if ({obs_a[i].d, obs_b[i].d} !== {8'h00, 8'h3C}) begin
            bad++; $display("FAIL reinit_word[%0d]: got a=%0h b=%0h want 0 3c", i, obs_a[i].d, obs_b[i].d);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rst = (i == 200 || i == 201);
         step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom),
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
         total++;
         if ({if_a.valid_1, if_a.collision_1, if_a.addr_err, if_a.ready, if_a.data_1} !==
             {exp_v[0], exp_c[0], exp_e[0], exp_r[0], exp_d[0]}) begin
            bad++; $display("FAIL random_a cyc %0d: got %0h want %0h", i,
                            {if_a.valid_1, if_a.collision_1, if_a.addr_err, if_a.ready, if_a.data_1},
                            {exp_v[0], exp_c[0], exp_e[0], exp_r[0], exp_d[0]});
         end
         total++;
         if ({if_b.valid_1, if_b.collision_1, if_b.addr_err, if_b.ready, if_b.data_1} !==
             {exp_v[1], exp_c[1], exp_e[1], exp_r[1], exp_d[1]}) begin
            bad++; $display("FAIL random_b cyc %0d: got %0h want %0h", i,
                            {if_b.valid_1, if_b.collision_1, if_b.addr_err, if_b.ready, if_b.data_1},
                            {exp_v[1], exp_c[1], exp_e[1], exp_r[1], exp_d[1]});
         end
      end
   endtask

   initial begin
      test_reset();
      test_init_contents();
      test_latency();
      test_collision();
      test_addr_err();
      test_reset_flush();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end
endmodule

// File: doc/syn_dual_port_ram.md
SYN_DUAL_PORT_RAM -- requirements
Module: syn_dual_port_ram

Interface
REQ-001 Parameter DATA_WIDTH, 8, word width in bits.
REQ-002 Parameter ADDR_WIDTH, 4, address width in bits.
REQ-003 Parameter DATA_DEPTH, (1 << ADDR_WIDTH), number of words; legal range 2..2**ADDR_WIDTH.
REQ-004 Parameter RD_LATENCY, 1, read latency in cycles; legal values 1 and 2 only.
REQ-005 Parameter RDW_MODE, 0, same-address read-during-write policy: 0 = read-old, 1 = write-through.
REQ-006 Parameter INIT_VALUE, 0, DATA_WIDTH-bit value written to every word during initialisation.
REQ-007 Port clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-008 Port rst  input  1  reset, synchronous, active-high.
REQ-009 Port addr_0  input  ADDR_WIDTH  write address.
REQ-010 Port we_0  input  1  write enable.
REQ-011 Port data_0  input  DATA_WIDTH  write data.
REQ-012 Port addr_1  input  ADDR_WIDTH  read address.
REQ-013 Port re_1  input  1  read request.
REQ-014 Port data_1  output  DATA_WIDTH  read data, registered, never tri-stated.
REQ-015 Port valid_1  output  1  one-cycle pulse qualifying data_1.
REQ-016 Port collision_1  output  1  pulse aligned with valid_1; marks a same-address read-during-write result.
REQ-017 Port addr_err  output  1  one-cycle pulse; an accepted request carried an address >= DATA_DEPTH.
REQ-018 Port ready  output  1  high once initialisation is complete.

Function
REQ-019 FSM states SHALL be INIT and RUN.
- INIT: writes INIT_VALUE to ram[cnt] each cycle, cnt = 0, 1, 2, ...
- INIT -> RUN: on the cycle cnt == DATA_DEPTH-1 is written.
- ready SHALL rise the following cycle, DATA_DEPTH cycles after rst deasserts.
REQ-020 In INIT, we_0 and re_1 SHALL be ignored: no write, no valid_1, no addr_err.
REQ-021 In RUN with we_0=1 and addr_0 < DATA_DEPTH, ram[addr_0] SHALL take data_0 at that clock edge.
REQ-022 In RUN with re_1=1, data_1 SHALL present ram[addr_1] and valid_1 SHALL pulse exactly RD_LATENCY cycles later.
- Back-to-back reads SHALL be accepted every cycle; throughput is one read per cycle.
REQ-023 When valid_1=0, data_1 SHALL hold its last value.
REQ-024 Same cycle we_0=1, re_1=1, addr_0==addr_1 (in range):
- RDW_MODE=0: returns the pre-write word.
- RDW_MODE=1: returns data_0.
- In both modes collision_1=1 with the corresponding valid_1.
REQ-025 Write with addr_0 >= DATA_DEPTH SHALL be dropped and addr_err SHALL pulse the next cycle.
REQ-026 Read with addr_1 >= DATA_DEPTH SHALL return INIT_VALUE with valid_1 and SHALL pulse addr_err the next cycle.
REQ-027 Simultaneous write and read to different addresses SHALL both complete without interaction.
REQ-028 addr_err SHALL pulse once when both ports are out of range in the same cycle.

Reset
REQ-029 While rst=1: state = INIT, cnt = 0, ready = 0, valid_1 = 0, collision_1 = 0, addr_err = 0, data_1 = 0.
REQ-030 rst asserted mid-operation SHALL flush in-flight reads (no later valid_1) and SHALL rerun the full initialisation sweep.
REQ-031 Memory contents are not reset directly; they are defined only by the INIT sweep.

Structure
REQ-032 Package syn_ram_pkg SHALL hold the INIT/RUN state encoding and the RDW_MODE constants (RDW_READ_OLD=0, RDW_WRITE_THROUGH=1).
REQ-033 Sub-module syn_ram_rd_pipe SHALL implement the RD_LATENCY-deep data/valid/collision pipeline with flush on rst.
REQ-034 The INIT FSM, the storage array and address checking SHALL stay in the top module.

Verification
REQ-035 Scenario: DATA_DEPTH=16, release rst -> ready rises exactly 16 cycles later; reading all 16 addresses returns 0x00.
REQ-036 Scenario: write 0xA5 to addr 3, read addr 3 next cycle, RD_LATENCY=2 -> data_1=0xA5, valid_1 high exactly 2 cycles after re_1.
REQ-037 Scenario: addr 5 holds 0x11; same-cycle write 0x22 and read at addr 5 -> RDW_MODE=0 gives 0x11, RDW_MODE=1 gives 0x22, collision_1=1 in both.
REQ-038 Scenario: DATA_DEPTH=12, write 0x7E to addr 13 -> addr_err pulses one cycle; reading addr 13 returns INIT_VALUE; no in-range word changes.
REQ-039 Scenario: issue 4 back-to-back reads, assert rst after the 2nd -> no valid_1 after rst; ready low for 16 cycles; memory reads all INIT_VALUE.
REQ-040 Scenario: assert we_0/re_1 during INIT -> no write occurs, valid_1 and addr_err stay 0.
